sync_fifo_mem: RTL and testbench
================================

SYNC_FIFO_MEM -- requirements
Module: sync_fifo_mem

Interface
REQ-001 Parameter: DATA_W, default 8, data width in bits.
REQ-002 Parameter: ADDR_W, default 8, address width; DEPTH = 2**ADDR_W entries (256 by default).
REQ-003 Parameter: AFULL_MARGIN, default 4, almost_full asserts when free entries <= AFULL_MARGIN.
REQ-004 Parameter: AEMPTY_MARGIN, default 4, almost_empty asserts when stored entries <= AEMPTY_MARGIN.
REQ-005 Port: clk  input  1  single clock; all state updates on posedge.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: wr_en  input  1  write request.
REQ-008 Port: wr_data  input  DATA_W  write data.
REQ-009 Port: rd_en  input  1  read request.
REQ-010 Port: rd_data  output  DATA_W  registered read data.
REQ-011 Port: rd_valid  output  1  rd_data holds a newly popped word this cycle.
REQ-012 Port: full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-013 Port: count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
REQ-014 Port (SYNC_FIFO_ERR_EN only): overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Storage SHALL be an internal DEPTH x DATA_W array with write pointer wp and read pointer rp, each ADDR_W bits, wrapping modulo DEPTH.
REQ-016 Read accepted (rd_acc) SHALL equal rd_en && !empty.
REQ-017 Write accepted (wr_acc) SHALL equal wr_en && (!full || rd_acc).
REQ-018 On wr_acc the block SHALL store wr_data at mem[wp] and increment wp.
REQ-019 On rd_acc the block SHALL load mem[rp] into rd_data at the same edge and increment rp; read latency is one cycle from request to data.
REQ-020 rd_valid SHALL be registered rd_acc: high for exactly the cycle after each accepted read.
REQ-021 rd_data SHALL hold its last value when no read is accepted.
REQ-022 count SHALL increment on wr_acc only, decrement on rd_acc only, and hold when both or neither occur.
REQ-023 Flags SHALL be decoded from the registered count: empty = (count==0), full = (count==DEPTH), almost_full = (count >= DEPTH-AFULL_MARGIN), almost_empty = (count <= AEMPTY_MARGIN).
REQ-024 Empty with simultaneous wr_en and rd_en: the write SHALL be accepted and the read rejected; no bypass of wr_data to rd_data.
REQ-025 Full with simultaneous wr_en and rd_en: both SHALL be accepted, count stays DEPTH, and the oldest word is returned.
REQ-026 Rejected writes SHALL NOT modify memory or wp; rejected reads SHALL NOT modify rp or rd_data.
REQ-027 Data SHALL emerge in write order across pointer wrap-around.

Reset
REQ-028 rst_n low SHALL immediately clear wp, rp, count, rd_data (to 0) and rd_valid, independent of clk.
REQ-029 During reset, empty and almost_empty SHALL be 1, and full and almost_full SHALL be 0.
REQ-030 Memory contents SHALL NOT be reset; reset mid-operation SHALL discard all stored entries.
REQ-031 Requests in the first edge after rst_n rises SHALL be processed normally.

Configuration
REQ-032 Macro SYNC_FIFO_ERR_EN defined: overflow SHALL set on wr_en && !wr_acc, and underflow SHALL set on rd_en && empty; both stay set until reset.
REQ-033 Macro SYNC_FIFO_ERR_EN undefined: the overflow and underflow ports and their logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-034 Reset, then write 0x11,0x22,0x33, then read 3 -> rd_data 0x11,0x22,0x33 each one cycle after rd_en, rd_valid high 3 cycles, then empty=1 and count=0.
REQ-035 Write 256 words 0x00..0xFF -> full=1 and count=256; a 257th write is rejected (overflow=1 if enabled); reading all returns 0x00..0xFF.
REQ-036 With count=256, assert wr_en=1 (0xAA) and rd_en=1 -> count stays 256, rd_data=0x00; after draining, 0xAA is the last word out.
REQ-037 Empty FIFO, wr_en=rd_en=1 with 0x5C -> count=1, rd_valid=0 next cycle; the following read returns 0x5C.
REQ-038 Fill to count=251, then write 1 more -> almost_full rises at count=252; drain to count=4 -> almost_empty rises.
REQ-039 Pull rst_n low mid-clock at count=10 -> count=0, empty=1, and rd_valid=0 before the next edge; a later read with rd_en=1 is rejected (underflow=1 if enabled).

Source files
------------

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: single-clock FIFO over an internal DEPTH x DATA_W array.
// Registered read data (one-cycle latency), occupancy count and status
// flags decoded from that count. Define SYNC_FIFO_ERR_EN to add the sticky
// overflow/underflow error ports; without it those ports do not exist.
module sync_fifo_mem #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int AFULL_MARGIN  = 4,
  parameter int AEMPTY_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;

  // Thresholds held at count width so every flag compare is width-matched.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_THR  = (ADDR_W+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [ADDR_W:0] AE_THR  = (ADDR_W+1)'(AEMPTY_MARGIN);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wp;
  logic [ADDR_W-1:0] r_rp;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

  // Flags come straight off the registered count, so reset forces
  // empty/almost_empty high and full/almost_full low with no clock needed.
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == DEPTH_C);
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= AF_THR);
  assign almost_empty = (r_count <= AE_THR);

  // A full FIFO still takes a write when a read frees a slot in the same
  // cycle; an empty FIFO never bypasses write data to the read side.
  assign w_rd_acc = rd_en && !w_empty;
  assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

  // Storage array: not reset, only written on an accepted write.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wp] <= wr_data;
  end

  // Write pointer advances only on accepted writes, wrapping modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_wp <= '0;
    else if (w_wr_acc) r_wp <= r_wp + PTR_ONE;
  end

  // Read pointer and read data: mem[rp] captured at the accepting edge.
  // When full with simultaneous read/write, wp==rp and the non-blocking
  // read returns the old (oldest) word before it is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rp      <= '0;
      r_rd_data <= '0;
    end else if (w_rd_acc) begin
      r_rp      <= r_rp + PTR_ONE;
      r_rd_data <= r_mem[r_rp];
    end
  end

  // rd_valid marks the single cycle after each accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_valid <= 1'b0;
    else        r_rd_valid <= w_rd_acc;
  end

  // Occupancy: moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags: a dropped write or a read against an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && !w_wr_acc) r_overflow  <= 1'b1;
      if (rd_en && w_empty)   r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_mem.sv
// tb_sync_fifo_mem: scoreboard bench for sync_fifo_mem (default parameters).
// A queue model decides acceptance each cycle; popped words are pushed to an
// expected-data queue and compared when rd_valid shows up one cycle later.
module tb_sync_fifo_mem;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
`ifdef SYNC_FIFO_ERR_EN
  logic          overflow, underflow;
`endif

  sync_fifo_mem #(.DATA_W(DW), .ADDR_W(AW), .AFULL_MARGIN(4), .AEMPTY_MARGIN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef SYNC_FIFO_ERR_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd;
  logic          exp_ovf, exp_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_status(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, ".full"},  32'(full),  32'(sz == DEPTH));
    chk({tag, ".afull"}, 32'(almost_full),  32'(sz >= DEPTH - 4));
    chk({tag, ".aempty"},32'(almost_empty), 32'(sz <= 4));
`ifdef SYNC_FIFO_ERR_EN
    chk({tag, ".ovf"}, 32'(overflow),  32'(exp_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
`endif
  endtask

  // One clock of stimulus; outputs sampled 1 time unit after the edge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    logic racc, wacc;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    racc = re && (model_q.size() != 0);
    wacc = we && ((model_q.size() != DEPTH) || racc);
    if (re && model_q.size() == 0) exp_unf = 1'b1;
    if (we && !wacc)               exp_ovf = 1'b1;
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(wd);
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(racc));
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("sb_extra", 32'(rd_data), 32'hFFFF_FFFF);
      else begin
        last_rd = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(last_rd));
      end
    end else begin
      chk("rd_hold", 32'(rd_data), 32'(last_rd));
    end
    chk_status("st");
  endtask

  task automatic clear_model();
    model_q.delete();
    exp_q.delete();
    last_rd = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  initial begin
    wr_en = 0; wr_data = '0; rd_en = 0;
    clear_model();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.rd_data",  32'(rd_data),  32'd0);
    chk_status("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release: three writes then three reads.
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    chk("basic.empty", 32'(empty), 32'd1);

    // Fill to 251, then cross the almost_full threshold at 252.
    for (int i = 0; i < 251; i++) step(1, 8'(i), 0);
    chk("af.251", 32'(almost_full), 32'd0);
    step(1, 8'(251), 0);
    chk("af.252", 32'(almost_full), 32'd1);
    for (int i = 252; i < 256; i++) step(1, 8'(i), 0);
    chk("full.flag",  32'(full),  32'd1);
    chk("full.count", 32'(count), 32'd256);
    // Write while full is dropped.
    step(1, 8'hEE, 0);
    chk("full.reject", 32'(count), 32'd256);
    // Full with simultaneous read/write: oldest out, count holds.
    step(1, 8'hAA, 1);
    chk("fullrw.data",  32'(rd_data), 32'h00);
    chk("fullrw.count", 32'(count),   32'd256);
    // Drain down to 5, then 4 raises almost_empty.
    while (model_q.size() > 5) step(0, 8'h00, 1);
    chk("ae.5", 32'(almost_empty), 32'd0);
    step(0, 8'h00, 1);
    chk("ae.4", 32'(almost_empty), 32'd1);
    while (model_q.size() > 0) step(0, 8'h00, 1);
    chk("drain.last", 32'(rd_data), 32'hAA);
    step(0, 8'h00, 0);

    // Empty with simultaneous read/write: write only, no bypass.
    step(1, 8'h5C, 1);
    chk("emptyrw.count", 32'(count),    32'd1);
    chk("emptyrw.vld",   32'(rd_valid), 32'd0);
    step(0, 8'h00, 1);
    chk("emptyrw.data",  32'(rd_data),  32'h5C);

    // Random traffic across pointer wrap-around.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50));
    while (model_q.size() > 0) step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    // Build count=10 with a read in the last cycle, then async reset mid-clock.
    for (int i = 0; i < 11; i++) step(1, 8'(8'h40 + i), 0);
    step(0, 8'h00, 1);
    chk("pre_rst.count", 32'(count), 32'd10);
    wr_en = 0; rd_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("mid_rst.count", 32'(count),    32'd0);
    chk("mid_rst.empty", 32'(empty),    32'd1);
    chk("mid_rst.vld",   32'(rd_valid), 32'd0);
    chk("mid_rst.data",  32'(rd_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 1);
    chk("post_rst.rej", 32'(rd_valid), 32'd0);
    step(1, 8'h77, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
